// File: rtl/svf_pkg.sv
// Shared widths, slot timing and FSM encoding for the SVF voice scheduler.
// Optional voice-clear support is enabled with SVF_SCHED_CLEAR_EN.
package svf_pkg;

    localparam int F_W         = 18;
    localparam int Q_W         = 18;
    localparam int IN_W        = 12;
    localparam int OUT_W       = 18;
    localparam int SEL_W       = 3;
    localparam int SLOT_CYCLES = 5;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic [F_W-1:0] f;
        logic [Q_W-1:0] q;
    } vparam_t;

endpackage

// File: rtl/svf_param_rf.sv
// Per-voice f/q register file: one write port, async read.
// A write to the address being read is returned in the same cycle.
module svf_param_rf
    import svf_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [SEL_W-1:0] waddr,
    input  vparam_t          wdata,
    input  logic [SEL_W-1:0] raddr,
    output vparam_t          rdata
);

    vparam_t mem [DEPTH];

    // storage, cleared on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // write-first read bypass
    always_comb begin
        rdata = mem[raddr];
        if (we && (waddr == raddr)) begin
            rdata = wdata;
        end
    end

endmodule

// File: rtl/svf_voice_scheduler.sv
// Walks all voices through the shared-multiplier SVF each sample tick and mixes them.
// Define SVF_SCHED_CLEAR_EN to add clr_req and drive svf_reset per voice slot.
module svf_voice_scheduler
    import svf_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int MIX_W      = 21
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_tick,
    input  logic                  cfg_we,
    input  logic [SEL_W-1:0]      cfg_addr,
    input  logic [F_W-1:0]        cfg_f,
    input  logic [Q_W-1:0]        cfg_q,
    output logic [SEL_W-1:0]      in_sel,
    input  logic [IN_W-1:0]       in_sample,
    output logic                  svf_ena,
    output logic [SEL_W-1:0]      svf_sel,
    output logic [F_W-1:0]        svf_f,
    output logic [Q_W-1:0]        svf_q,
    output logic [IN_W-1:0]       svf_in,
    input  logic [OUT_W-1:0]      svf_out,
    output logic [OUT_W-1:0]      voice_out,
    output logic                  voice_valid,
    output logic [SEL_W-1:0]      voice_idx,
    output logic [MIX_W-1:0]      mix_out,
    output logic                  mix_valid,
    output logic                  busy,
    output logic                  overrun,
`ifdef SVF_SCHED_CLEAR_EN
    input  logic [NUM_VOICES-1:0] clr_req,
`endif
    output logic                  svf_reset
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_VOICES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(SLOT_CYCLES - 2);

    state_t            state;
    logic [SEL_W-1:0]  voice;
    logic [CNT_W-1:0]  slot_cnt;
    logic [MIX_W-1:0]  acc;
    vparam_t           rd;
    vparam_t           snap;
    vparam_t           wr;
    logic [IN_W-1:0]   snap_in;
    logic              issue;
    logic              slot_end;

    assign wr       = {cfg_f, cfg_q};
    assign issue    = (state == ISSUE);
    assign slot_end = (state == RUN) && (slot_cnt == RUN_LAST);

    svf_param_rf #(
        .DEPTH (8)
    ) u_rf (
        .clk   (clk),
        .reset (reset),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (wr),
        .raddr (voice),
        .rdata (rd)
    );

    // ISSUE passes the live file/input through; RUN holds the slot snapshot
    assign in_sel  = voice;
    assign svf_sel = voice;
    assign svf_f   = issue ? rd.f : snap.f;
    assign svf_q   = issue ? rd.q : snap.q;
    assign svf_in  = issue ? in_sample : snap_in;

    // scheduling FSM, capture and mix accumulation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            voice       <= '0;
            slot_cnt    <= '0;
            acc         <= '0;
            snap        <= '0;
            snap_in     <= '0;
            svf_ena     <= 1'b0;
            voice_out   <= '0;
            voice_valid <= 1'b0;
            voice_idx   <= '0;
            mix_out     <= '0;
            mix_valid   <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            svf_ena     <= 1'b0;
            voice_valid <= 1'b0;
            mix_valid   <= 1'b0;
            if (sample_tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (sample_tick) begin
                        state   <= ISSUE;
                        voice   <= '0;
                        acc     <= '0;
                        svf_ena <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ISSUE: begin
                    snap     <= rd;
                    snap_in  <= in_sample;
                    slot_cnt <= '0;
                    state    <= RUN;
                end
                RUN: begin
                    slot_cnt <= slot_cnt + 1'b1;
                    if (slot_cnt == RUN_LAST) begin
                        voice_out   <= svf_out;
                        voice_idx   <= voice;
                        voice_valid <= 1'b1;
                        acc <= acc + {{(MIX_W-OUT_W){svf_out[OUT_W-1]}}, svf_out};
                        if (voice == LAST) begin
                            state <= DONE;
                        end else begin
                            voice   <= voice + 1'b1;
                            svf_ena <= 1'b1;
                            state   <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    mix_out   <= acc;
                    mix_valid <= 1'b1;
                    busy      <= 1'b0;
                    voice     <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SVF_SCHED_CLEAR_EN
    logic [NUM_VOICES-1:0] clr_pend;
    logic [NUM_VOICES-1:0] take;
    logic [SEL_W-1:0]      nxt_voice;
    logic                  slot_start;

    // which voice slot starts next cycle and which clear bit it consumes
    always_comb begin
        slot_start = ((state == IDLE) && sample_tick) ||
                     (slot_end && (voice != LAST));
        nxt_voice  = (state == IDLE) ? '0 : voice + 1'b1;
        take       = '0;
        if (slot_start) begin
            take = NUM_VOICES'(1) << nxt_voice;
        end
    end

    // pending clears; requests landing inside a slot wait for the next round
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_pend  <= '0;
            svf_reset <= 1'b0;
        end else begin
            clr_pend <= (clr_pend | clr_req) & ~take;
            if (slot_start) begin
                svf_reset <= |((clr_pend | clr_req) & take);
            end else if (slot_end) begin
                svf_reset <= 1'b0;
            end
        end
    end
`else
    assign svf_reset = 1'b0;
`endif

endmodule

// File: tb/tb_svf_voice_scheduler.sv
// Self-checking bench for svf_voice_scheduler with a behavioural filter model.
// Build with SVF_SCHED_CLEAR_EN defined to also exercise the voice-clear path.
module tb_svf_voice_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sample_tick = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [17:0] cfg_f = '0;
    logic [17:0] cfg_q = '0;
    logic [2:0]  in_sel;
    logic [11:0] in_sample = '0;
    logic        svf_ena;
    logic [2:0]  svf_sel;
    logic [17:0] svf_f;
    logic [17:0] svf_q;
    logic [11:0] svf_in;
    logic [17:0] svf_out;
    logic [17:0] voice_out;
    logic        voice_valid;
    logic [2:0]  voice_idx;
    logic [20:0] mix_out;
    logic        mix_valid;
    logic        busy;
    logic        overrun;
    logic [7:0]  clr_req = '0;
    logic        svf_reset;

    int n_cmp = 0;
    int n_bad = 0;

    // reference state
    logic [17:0] otab [8];
    logic [11:0] itab [8];
    logic [17:0] m_f [8];
    logic [17:0] m_q [8];
    logic [7:0]  m_clr = '0;

    always #5 clk = ~clk;

    svf_voice_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_f       (cfg_f),
        .cfg_q       (cfg_q),
        .in_sel      (in_sel),
        .in_sample   (in_sample),
        .svf_ena     (svf_ena),
        .svf_sel     (svf_sel),
        .svf_f       (svf_f),
        .svf_q       (svf_q),
        .svf_in      (svf_in),
        .svf_out     (svf_out),
        .voice_out   (voice_out),
        .voice_valid (voice_valid),
        .voice_idx   (voice_idx),
        .mix_out     (mix_out),
        .mix_valid   (mix_valid),
        .busy        (busy),
        .overrun     (overrun),
`ifdef SVF_SCHED_CLEAR_EN
        .clr_req     (clr_req),
`endif
        .svf_reset   (svf_reset)
    );

    // filter model: result only valid on the 4th cycle after ena
    logic [2:0] fsel = '0;
    int         fcnt = 0;
    always @(posedge clk) begin
        if (svf_ena) begin
            fsel <= svf_sel;
            fcnt <= 1;
        end else if (fcnt > 0 && fcnt < 100) begin
            fcnt <= fcnt + 1;
        end
    end
    assign svf_out = (fcnt == 4) ? otab[fsel] : ~otab[fsel];

    typedef struct packed {
        logic [7:0][17:0] outs;
        longint           mix;
    } vec_t;

    vec_t vt [4];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cfg_write(input int v, input logic [17:0] f, input logic [17:0] q);
        cfg_we   = 1'b1;
        cfg_addr = 3'(v);
        cfg_f    = f;
        cfg_q    = q;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        m_f[v] = f;
        m_q[v] = q;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin
            m_f[i] = '0;
            m_q[i] = '0;
        end
        m_clr = '0;
    endtask

    // one full round; cycle 0 is the first cycle after the tick is sampled
    task automatic run_round(input bit start, input int tick_c,
                             input int wr_c, input int wr_v,
                             input logic [17:0] wr_f, input logic [17:0] wr_q,
                             input int clr_c, input logic [7:0] clr_bits);
        logic [17:0] sf [8];
        logic [17:0] sq [8];
        logic [11:0] si [8];
        logic        sc [8];
        int ena_bad = 0;
        int vv_n = 0;
        int vv_bad = 0;
        int mv_n = 0;
        int mv_bad = 0;
        int busy_bad = 0;
        int hold_bad = 0;
        int rst_bad = 0;
        longint exp_mix = 0;
        logic [20:0] mix_seen = '0;
        for (int k = 0; k < 8; k++) begin
            exp_mix += longint'($signed(otab[k]));
        end
        if (start) begin
            sample_tick = 1'b1;
            @(posedge clk);
            #1;
        end
        for (int c = 0; c < 42; c++) begin
            int k;
            sample_tick = (c == tick_c);
            cfg_we = (c == wr_c);
            if (c == wr_c) begin
                cfg_addr = 3'(wr_v);
                cfg_f    = wr_f;
                cfg_q    = wr_q;
                m_f[wr_v] = wr_f;
                m_q[wr_v] = wr_q;
            end
            clr_req = (c == clr_c) ? clr_bits : 8'h00;
            in_sample = (c % 5 == 0) ? itab[in_sel] : 12'($urandom);
            if (c < 40 && c % 5 == 0) begin
                k = c / 5;
                sf[k] = m_f[k];
                sq[k] = m_q[k];
                si[k] = itab[k];
                sc[k] = m_clr[k];
                m_clr[k] = 1'b0;
            end
            if (c == clr_c) begin
                m_clr = m_clr | clr_bits;
            end
            #1;
            if (svf_ena !== ((c < 40) && (c % 5 == 0))) ena_bad++;
            if (busy !== (c <= 40)) busy_bad++;
            if (c < 40) begin
                k = c / 5;
                if (svf_sel !== 3'(k) || in_sel !== 3'(k) ||
                    svf_f !== sf[k] || svf_q !== sq[k] ||
                    svf_in !== si[k]) hold_bad++;
                if (svf_reset !== sc[k]) rst_bad++;
            end else if (svf_reset !== 1'b0) begin
                rst_bad++;
            end
            if (voice_valid) begin
                if (c != 5 * (vv_n + 1) || voice_idx !== 3'(vv_n) ||
                    voice_out !== otab[vv_n[2:0]]) vv_bad++;
                vv_n++;
            end
            if (mix_valid) begin
                mv_n++;
                if (c != 41) mv_bad++;
                mix_seen = mix_out;
            end
            @(posedge clk);
            #1;
        end
        sample_tick = 1'b0;
        cfg_we      = 1'b0;
        clr_req     = 8'h00;
        chk("ena_timing", ena_bad, 0);
        chk("voice_valid_count", vv_n, 8);
        chk("voice_valid_data", vv_bad, 0);
        chk("mix_valid_count", mv_n, 1);
        chk("mix_valid_timing", mv_bad, 0);
        chk("mix_out_sum", longint'($signed(mix_seen)), exp_mix);
        chk("busy_window", busy_bad, 0);
        chk("slot_hold", hold_bad, 0);
        chk("svf_reset_window", rst_bad, 0);
    endtask

    task automatic rand_tabs();
        for (int k = 0; k < 8; k++) begin
            otab[k] = 18'($urandom);
            itab[k] = 12'($urandom);
        end
    endtask

    initial begin
        vt[0].outs = {8{18'd100}};
        vt[0].mix  = 800;
        vt[1].outs = {18'h20000, 18'd6000, 18'd5000, 18'd4000,
                      18'd3000, 18'd2000, 18'd1000, 18'd0};
        vt[1].mix  = -110072;
        vt[2].outs = {8{18'h20000}};
        vt[2].mix  = -1048576;
        vt[3].outs = {8{18'h1FFFF}};
        vt[3].mix  = 1048568;

        for (int k = 0; k < 8; k++) begin
            otab[k] = '0;
            itab[k] = '0;
        end
        clear_model();

        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ena", svf_ena, 0);
        chk("rst_mix_valid", mix_valid, 0);
        chk("rst_mix_out", mix_out, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_svf_f", svf_f, 0);
        chk("rst_in_sel", in_sel, 0);
        chk("rst_voice_valid", voice_valid, 0);
        chk("rst_svf_reset", svf_reset, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        cfg_write(3, 18'h04000, 18'h10000);
        cfg_write(6, 18'h00123, 18'h3FF00);

        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 8; k++) begin
                otab[k] = vt[i].outs[k];
                itab[k] = 12'($urandom);
            end
            run_round(1'b1, -1, -1, 0, '0, '0, -1, 8'h00);
            chk("vec_mix", longint'($signed(mix_out)), vt[i].mix);
        end

        // cfg writes around voice3's slot
        rand_tabs();
        run_round(1'b1, -1, 15, 3, 18'h0ABCD, 18'h01111, -1, 8'h00);
        run_round(1'b1, -1, 17, 3, 18'h05555, 18'h02222, -1, 8'h00);
        run_round(1'b1, -1, -1, 0, '0, '0, -1, 8'h00);
        run_round(1'b1, -1, 14, 3, 18'h3C3C3, 18'h00007, -1, 8'h00);

        // overrun behaviour
        chk("overrun_clear", overrun, 0);
        run_round(1'b1, 20, -1, 0, '0, '0, -1, 8'h00);
        chk("overrun_mid", overrun, 1);
        run_round(1'b1, 41, -1, 0, '0, '0, -1, 8'h00);
        chk("tick42_busy", busy, 1);
        chk("overrun_sticky", overrun, 1);
        run_round(1'b0, -1, -1, 0, '0, '0, -1, 8'h00);
        reset = 1'b1;
        #1;
        clear_model();
        chk("overrun_reset", overrun, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_round(1'b1, 40, -1, 0, '0, '0, -1, 8'h00);
        chk("overrun_done", overrun, 1);
        chk("done_tick_ignored", busy, 0);

        // random rounds
        for (int r = 0; r < 12; r++) begin
            rand_tabs();
            cfg_write($urandom_range(0, 7), 18'($urandom), 18'($urandom));
            run_round(1'b1, -1, $urandom_range(0, 45), $urandom_range(0, 7),
                      18'($urandom), 18'($urandom), -1, 8'h00);
        end

        // reset in the middle of a round
        begin
            int mv = 0;
            int bz = 0;
            sample_tick = 1'b1;
            @(posedge clk);
            #1;
            sample_tick = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            sample_tick = 1'b1;
            @(posedge clk);
            #1;
            sample_tick = 1'b0;
            repeat (6) @(posedge clk);
            #1;
            chk("mid_overrun", overrun, 1);
            reset = 1'b1;
            #1;
            clear_model();
            chk("mid_rst_busy", busy, 0);
            chk("mid_rst_overrun", overrun, 0);
            chk("mid_rst_mix_out", mix_out, 0);
            chk("mid_rst_sel", svf_sel, 0);
            chk("mid_rst_out", voice_out, 0);
            @(posedge clk);
            #1;
            reset = 1'b0;
            for (int c = 0; c < 45; c++) begin
                if (mix_valid) mv++;
                if (busy) bz++;
                @(posedge clk);
                #1;
            end
            chk("mid_rst_no_mix", mv, 0);
            chk("mid_rst_idle", bz, 0);
            rand_tabs();
            run_round(1'b1, -1, -1, 0, '0, '0, -1, 8'h00);
        end

`ifdef SVF_SCHED_CLEAR_EN
        rand_tabs();
        clr_req = 8'h20;
        m_clr = m_clr | 8'h20;
        @(posedge clk);
        #1;
        clr_req = 8'h00;
        run_round(1'b1, -1, -1, 0, '0, '0, -1, 8'h00);
        run_round(1'b1, -1, -1, 0, '0, '0, -1, 8'h00);
        run_round(1'b1, -1, -1, 0, '0, '0, 27, 8'h20);
        run_round(1'b1, -1, -1, 0, '0, '0, 24, 8'h21);
        run_round(1'b1, -1, -1, 0, '0, '0, -1, 8'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
